// File: rtl/culsans_axi_err_slv.sv
// Error slave for unmapped crossbar addresses: every AW/W burst gets one
// B error beat, every AR (and every atomic AW with read data) gets R error
// beats carrying a fixed data pattern.
//
// Ports:
//   clk_i  - clock; all state changes on its rising edge
//   rst_i  - asynchronous, active-high reset
//   req_i  - AXI/ACE slave request (culsans_pkg::req_slv_t)
//   resp_o - AXI/ACE slave response (culsans_pkg::resp_slv_t)

package culsans_pkg;

    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
        logic [2:0]           snoop;
        logic [1:0]           bar;
        logic [1:0]           domain;
        logic                 awunique;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
        logic [3:0]           snoop;
        logic [1:0]           bar;
        logic [1:0]           domain;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [3:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
        logic     wack;
        logic     rack;
    } req_slv_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_slv_t;

endpackage

module culsans_axi_err_slv
    import culsans_pkg::*;
#(
    parameter logic [1:0]  RespCode = 2'b11,
    parameter logic [63:0] RespData = 64'hBADC_AB1E_BADC_AB1E
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  req_slv_t  req_i,
    output resp_slv_t resp_o
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e           w_state_q, w_state_d;
    r_state_e           r_state_q, r_state_d;
    logic [IdWidth-1:0] w_id_q;
    logic [5:0]         w_atop_q;
    logic [IdWidth-1:0] r_id_q, r_id_d;
    logic [7:0]         r_len_q, r_len_d;
    logic [7:0]         r_cnt_q, r_cnt_d;
    // Keeps both readies low until the first edge after reset release.
    logic               ready_en_q;

    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic aw_atomic, aw_hs, atomic_hs, w_hs, b_hs, ar_hs, r_hs, r_last;

    // ACE snoop/bar/domain/awunique, addresses, W payload and acks carry
    // no meaning for an error slave.
    logic unused_inputs;
    assign unused_inputs = ^{req_i, w_atop_q};

    assign aw_atomic = req_i.aw.atop[5];
    assign aw_hs     = req_i.aw_valid & aw_ready;
    assign atomic_hs = aw_hs & aw_atomic;
    assign w_hs      = req_i.w_valid & w_ready;
    assign b_hs      = b_valid & req_i.b_ready;
    assign ar_hs     = req_i.ar_valid & ar_ready;
    assign r_hs      = r_valid & req_i.r_ready;
    // Compare rather than count down so len=255 never relies on wrap.
    assign r_last    = (r_cnt_q == r_len_q);

    // ---------------- write path ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q  <= W_IDLE;
            w_id_q     <= '0;
            w_atop_q   <= '0;
            ready_en_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            ready_en_q <= 1'b1;
            if (aw_hs) begin
                w_id_q   <= req_i.aw.id;
                w_atop_q <= req_i.aw.atop;
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && req_i.w.last) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        unique case (w_state_q)
            // An atomic with read data needs the read path free.
            W_IDLE:  aw_ready = ready_en_q &
                                (~aw_atomic | (r_state_q == R_IDLE));
            W_DATA:  w_ready  = 1'b1;
            W_RESP:  b_valid  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- read path ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (atomic_hs) begin
                    r_state_d = R_DATA;
                    r_id_d    = req_i.aw.id;
                    r_len_d   = req_i.aw.len;
                    r_cnt_d   = '0;
                end else if (ar_hs) begin
                    r_state_d = R_DATA;
                    r_id_d    = req_i.ar.id;
                    r_len_d   = req_i.ar.len;
                    r_cnt_d   = '0;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    r_cnt_d = r_cnt_q + 8'd1;
                    if (r_last) r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        unique case (r_state_q)
            // A simultaneously accepted atomic AW owns the read path.
            R_IDLE:  ar_ready = ready_en_q & ~atomic_hs;
            R_DATA:  r_valid  = 1'b1;
            default: ;
        endcase
    end

    // ---------------- response bundle ----------------
    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = aw_ready;
        resp_o.w_ready  = w_ready;
        resp_o.b_valid  = b_valid;
        resp_o.ar_ready = ar_ready;
        resp_o.r_valid  = r_valid;
        if (b_valid) begin
            resp_o.b.id   = w_id_q;
            resp_o.b.resp = RespCode;
        end
        if (r_valid) begin
            resp_o.r.id   = r_id_q;
            resp_o.r.data = RespData;
            resp_o.r.resp = {2'b00, RespCode};
            resp_o.r.last = r_last;
        end
    end

endmodule
